// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared defaults and helpers for the RAM-backed FIFO.
// Optional feature macro used by this block: RAM_FIFO_FWFT_EN.
package ram_fifo_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 6;
    localparam int AFULL_TH_DEF = 56;

    // Occupancy counter must hold 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_if.sv
// ram_fifo_if: write/read/status bundle between a FIFO user (master) and
// the FIFO itself (slave). Clock and reset stay outside the bundle.
interface ram_fifo_if
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic                       clr;
    logic                       wr_en;
    logic [DATA_W-1:0]          din;
    logic                       rd_en;
    logic [DATA_W-1:0]          dout;
    logic                       dout_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic [cnt_w(ADDR_W)-1:0]   count;
    logic                       ovf_err;
    logic                       udf_err;

    modport master (
        output clr, wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, count, ovf_err, udf_err
    );

    modport slave (
        input  clr, wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, count, ovf_err, udf_err
    );

endinterface

// File: rtl/ram_dp.sv
// ram_dp: simple dual-port RAM, one write port and one registered read
// port on the same clock. No reset on storage or read register.
module ram_dp
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clka,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port.
    always_ff @(posedge clka) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: one-cycle latency, holds its value when not enabled.
    always_ff @(posedge clka) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ram_fifo.sv
// ram_fifo: synchronous FIFO on top of ram_dp. Owns pointers, occupancy,
// registered status flags, sticky error flags and the output stage.
// Define RAM_FIFO_FWFT_EN for first-word-fall-through behaviour; default is
// standard mode where a pop presents its word one cycle later.
module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AFULL_TH = AFULL_TH_DEF
) (
    input  logic     clka,
    input  logic     rsta_n,
    ram_fifo_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = cnt_w(ADDR_W);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;
    logic              full_q;
    logic              afull_q;
    logic              vld_q;
    logic              vld_nxt;
    logic              ovf_q;
    logic              udf_q;
    logic              empty_now;
    logic              wr_acc;
    logic              rd_acc;
    logic              fetch;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] hold_q;

    // Writes are refused while full or during a flush.
    assign wr_acc = !bus.clr && bus.wr_en && !full_q;

`ifdef RAM_FIFO_FWFT_EN
    // The output stage holds the head word; the FIFO looks empty until a
    // word has actually been fetched from the RAM into that stage.
    assign empty_now = !vld_q;
    assign rd_acc    = !bus.clr && bus.rd_en && vld_q;
    // Fetch whenever the RAM holds words not yet presented and the stage is
    // free or being popped this cycle. count includes the presented word.
    assign fetch     = !bus.clr && (count_q != CW'(vld_q)) && (!vld_q || rd_acc);
    assign vld_nxt   = !bus.clr && (fetch || (vld_q && !rd_acc));
`else
    logic empty_q;

    // Registered empty flag, derived from next-cycle occupancy.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) empty_q <= 1'b1;
        else         empty_q <= (count_nxt == '0);
    end

    assign empty_now = empty_q;
    assign rd_acc    = !bus.clr && bus.rd_en && !empty_q;
    // A pop reads the RAM directly; its word shows up the following cycle.
    assign fetch     = rd_acc;
    assign vld_nxt   = rd_acc;
`endif

    // Next occupancy: simultaneous accepted write and read cancel out.
    always_comb begin
        count_nxt = count_q;
        if (bus.clr)
            count_nxt = '0;
        else if (wr_acc && !rd_acc)
            count_nxt = count_q + CW'(1);
        else if (rd_acc && !wr_acc)
            count_nxt = count_q - CW'(1);
    end

    // Pointers, occupancy, flags and output-stage state.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            afull_q <= (count_nxt >= CW'(AFULL_TH));
            vld_q   <= vld_nxt;
            if (bus.clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                udf_q  <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (fetch)  rd_ptr <= rd_ptr + ADDR_W'(1);
                // Errors are sticky: any attempt against the wrong flag counts.
                if (bus.wr_en && full_q)    ovf_q <= 1'b1;
                if (bus.rd_en && empty_now) udf_q <= 1'b1;
            end
        end
    end

    // Keep the last presented word so dout is stable when nothing is valid.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)    hold_q <= '0;
        else if (vld_q) hold_q <= rdata;
    end

    ram_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clka  (clka),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .re    (fetch),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign bus.dout        = vld_q ? rdata : hold_q;
    assign bus.dout_valid  = vld_q;
    assign bus.full        = full_q;
    assign bus.empty       = empty_now;
    assign bus.almost_full = afull_q;
    assign bus.count       = count_q;
    assign bus.ovf_err     = ovf_q;
    assign bus.udf_err     = udf_q;

endmodule

// File: tb/tb_ram_fifo.sv
// tb_ram_fifo: randomized scoreboard bench for ram_fifo. A queue-level model
// predicts occupancy, flags and output timing; written data is queued and a
// monitor compares every presented word against it.
module tb_ram_fifo;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int AFT   = 56;

    logic clka   = 1'b0;
    logic rsta_n = 1'b1;

    always #5 clka = ~clka;

    ram_fifo_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram_fifo #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AFULL_TH (AFT)
    ) dut (
        .clka   (clka),
        .rsta_n (rsta_n),
        .bus    (bus)
    );

    int            checks   = 0;
    int            failures = 0;
    int            mq[$];          // write-cycle stamp of each held word
    logic [DW-1:0] exp_q[$];       // data written, in order
    bit            m_ovf, m_udf, m_dv, mon_en;
    int            edge_n, pops;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_empty();
`ifdef RAM_FIFO_FWFT_EN
        return !m_dv;
`else
        return mq.size() == 0;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 0;
        m_udf = 0;
        m_dv  = 0;
    endtask

    // Effect of one clock edge with the given inputs, from the FIFO rules.
    task automatic model_edge(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
        int sz = mq.size();
        bit wa, ra;
        if (c) begin
            model_reset();
        end else begin
            wa = w && (sz != DEPTH);
`ifdef RAM_FIFO_FWFT_EN
            ra = r && m_dv;
`else
            ra = r && (sz != 0);
`endif
            if (w && sz == DEPTH) m_ovf = 1;
            if (r && m_empty())   m_udf = 1;
            if (ra) begin
                void'(mq.pop_front());
                pops++;
`ifdef RAM_FIFO_FWFT_EN
                void'(exp_q.pop_front());
`endif
            end
            if (wa) begin
                mq.push_back(edge_n);
                exp_q.push_back(d);
            end
`ifdef RAM_FIFO_FWFT_EN
            // Head becomes visible once it was written before this edge.
            m_dv = (mq.size() != 0) && (mq[0] < edge_n);
`else
            m_dv = ra;
`endif
        end
        edge_n++;
    endtask

    // Called just after a falling edge; returns at the next falling edge.
    task automatic step(input bit c, input bit w, input bit r, input logic [DW-1:0] d);
        bus.clr   = c;
        bus.wr_en = w;
        bus.rd_en = r;
        bus.din   = d;
        model_edge(c, w, r, d);
        @(posedge clka);
        @(negedge clka);
    endtask

    task automatic fill_to(input int n);
        for (int g = 0; g < 300 && mq.size() < n; g++) step(0, 1, 0, $urandom);
    endtask

    task automatic drain();
        for (int g = 0; g < 400 && mq.size() != 0; g++) step(0, 0, 1, '0);
    endtask

    // Monitor: compare status every cycle and data whenever dout_valid is high.
    always begin
        @(posedge clka);
        #1;
        if (mon_en) begin
            chk("count",       bus.count,       mq.size());
            chk("full",        bus.full,        mq.size() == DEPTH);
            chk("almost_full", bus.almost_full, mq.size() >= AFT);
            chk("empty",       bus.empty,       m_empty());
            chk("ovf_err",     bus.ovf_err,     m_ovf);
            chk("udf_err",     bus.udf_err,     m_udf);
            chk("dout_valid",  bus.dout_valid,  m_dv);
            if (bus.dout_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dout_unexpected actual=%0h expected=none at %0t", bus.dout, $time);
                end else begin
                    chk("dout", bus.dout, exp_q[0]);
`ifndef RAM_FIFO_FWFT_EN
                    void'(exp_q.pop_front());
`endif
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit w, r;
        int sz;
        bus.clr   = 0;
        bus.wr_en = 0;
        bus.rd_en = 0;
        bus.din   = '0;
        model_reset();
        edge_n = 0;
        pops   = 0;
        mon_en = 0;

        // Reset state
        #1 rsta_n = 1'b0;
        #2;
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full,  0);
        chk("rst_afull", bus.almost_full, 0);
        chk("rst_dv",    bus.dout_valid, 0);
        chk("rst_dout",  bus.dout, 0);
        chk("rst_ovf",   bus.ovf_err, 0);
        chk("rst_udf",   bus.udf_err, 0);
        @(negedge clka);
        @(negedge clka);
        rsta_n = 1'b1;
        mon_en = 1;

        // Fill 0x00..0x3F, overflow, drain in order, underflow, flush
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DW'(i));
        chk("fill_full",  bus.full, 1);
        chk("fill_count", bus.count, 64);
        chk("fill_afull", bus.almost_full, 1);
        step(0, 1, 0, 32'hdead);
        chk("ovf_count", bus.count, 64);
        chk("ovf_set",   bus.ovf_err, 1);
        drain();
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);
        chk("udf_set",   bus.udf_err, 1);
        chk("udf_dv",    bus.dout_valid, 0);
        chk("drain_empty", bus.empty, 1);
        step(1, 0, 0, '0);
        chk("clr_ovf",   bus.ovf_err, 0);
        chk("clr_udf",   bus.udf_err, 0);
        chk("clr_count", bus.count, 0);

        // Simultaneous write+read at 10, at empty, at full
        fill_to(10);
        for (int i = 0; i < 20; i++) step(0, 1, 1, $urandom);
        chk("sim10_count", bus.count, 10);
        drain();
        step(0, 0, 0, '0);
        step(0, 1, 1, $urandom);
        chk("sim0_count", bus.count, 1);
        for (int i = 0; i < 19; i++) step(0, 1, 1, $urandom);
        fill_to(DEPTH);
        step(0, 1, 1, $urandom);
        chk("sim64_count", bus.count, 63);
        chk("sim64_ovf",   bus.ovf_err, 1);
        for (int i = 0; i < 19; i++) step(0, 1, 1, $urandom);

        // Wrap-around with occupancy held in 3..5
        step(1, 0, 0, '0);
        fill_to(3);
        pops = 0;
        for (int g = 0; g < 3000 && pops < 200; g++) begin
            sz = mq.size();
            w  = (sz < 5) && ($urandom_range(0, 1) == 1);
            r  = (sz > 3) && ($urandom_range(0, 1) == 1);
            step(0, w, r, $urandom);
        end

        // Random traffic, alternating fill-heavy and drain-heavy phases
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 100; i++) begin
                w = $urandom_range(0, 99) < ((p % 2 == 0) ? 80 : 30);
                r = $urandom_range(0, 99) < ((p % 2 == 0) ? 30 : 80);
                step($urandom_range(0, 63) == 0, w, r, $urandom);
            end
        end

        // Asynchronous reset with count=20 and a read pending
        step(1, 0, 0, '0);
        fill_to(20);
        bus.wr_en = 0;
        bus.clr   = 0;
        bus.rd_en = 1;
        #2 rsta_n = 1'b0;
        #1;
        chk("amid_count", bus.count, 0);
        chk("amid_empty", bus.empty, 1);
        chk("amid_full",  bus.full, 0);
        chk("amid_afull", bus.almost_full, 0);
        chk("amid_dv",    bus.dout_valid, 0);
        chk("amid_dout",  bus.dout, 0);
        chk("amid_ovf",   bus.ovf_err, 0);
        chk("amid_udf",   bus.udf_err, 0);
        model_reset();
        @(negedge clka);
        rsta_n    = 1'b1;
        bus.rd_en = 0;
        step(0, 0, 0, '0);
        chk("post_rst_dv", bus.dout_valid, 0);
        step(0, 1, 0, 32'h5a5a_0001);
        step(0, 1, 0, 32'h5a5a_0002);
        drain();

`ifdef RAM_FIFO_FWFT_EN
        // Fall-through: word visible two cycles after its write
        step(1, 0, 0, '0);
        step(0, 1, 0, 32'hA5);
        chk("fwft_dv1", bus.dout_valid, 0);
        step(0, 0, 0, '0);
        chk("fwft_dv2",  bus.dout_valid, 1);
        chk("fwft_dout", bus.dout, 32'hA5);
        step(0, 0, 1, '0);
        chk("fwft_empty", bus.empty, 1);
`endif

        drain();
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("sb_leftover", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
